// File: rtl/video_timing_gen.sv
// Pixel-enable and raster timing generator: ce_pix divider, h/v counters and
// registered blank/sync/frame_start for NTSC/PAL with optional 31 kHz doubling.
module video_timing_gen #(
  parameter int CE_DIV       = 4,
  parameter int H_ACTIVE     = 256,
  parameter int H_SYNC_START = 270,
  parameter int H_SYNC_END   = 294,
  parameter int H_TOTAL      = 320,
  parameter int V_ACTIVE     = 240,
  parameter int V_SYNC_START = 244,
  parameter int V_SYNC_LEN   = 3,
  parameter int V_TOTAL_NTSC = 262,
  parameter int V_TOTAL_PAL  = 312
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pal,
  input  logic       scandouble,
  output logic       ce_pix,
  output logic [8:0] hcount,
  output logic [9:0] vcount,
  output logic       HBlank,
  output logic       HSync,
  output logic       VBlank,
  output logic       VSync,
  output logic       frame_start
);

  localparam int DW = $clog2(CE_DIV);
  localparam logic [DW-1:0] DIV_ONE      = DW'(1);
  localparam logic [DW-1:0] DIV_LAST_15K = DW'(CE_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST_31K = DW'(CE_DIV / 2 - 1);

  localparam logic [8:0] H_LAST    = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_ACT     = 9'(H_ACTIVE);
  localparam logic [8:0] HS_BEG    = 9'(H_SYNC_START);
  localparam logic [8:0] HS_END    = 9'(H_SYNC_END);

  localparam logic [9:0] VL_N15    = 10'(V_TOTAL_NTSC - 1);
  localparam logic [9:0] VL_N31    = 10'(2 * V_TOTAL_NTSC - 1);
  localparam logic [9:0] VL_P15    = 10'(V_TOTAL_PAL - 1);
  localparam logic [9:0] VL_P31    = 10'(2 * V_TOTAL_PAL - 1);
  localparam logic [9:0] V_ACT_15K = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_31K = 10'(2 * V_ACTIVE);
  localparam logic [9:0] VS_BEG_15K = 10'(V_SYNC_START);
  localparam logic [9:0] VS_BEG_31K = 10'(2 * V_SYNC_START);
  localparam logic [9:0] VS_END_15K = 10'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [9:0] VS_END_31K = 10'(2 * (V_SYNC_START + V_SYNC_LEN));

  logic [DW-1:0] div_q, div_d;
  logic          ce_pix_q, ce_pix_d;
  logic [8:0]    hcount_q, hcount_d;
  logic [9:0]    vcount_q, vcount_d;
  logic          hblank_q, hblank_d;
  logic          hsync_q, hsync_d;
  logic          vblank_q, vblank_d;
  logic          vsync_q, vsync_d;
  logic          frame_start_q, frame_start_d;
  logic          mode_pal_q, mode_pal_d;
  logic          mode_sd_q, mode_sd_d;

  logic [DW-1:0] div_last_s;
  logic [9:0]    v_last_s;
  logic [9:0]    v_act_s;
  logic [9:0]    vs_beg_s;
  logic [9:0]    vs_end_s;

  // Line count of the frame in progress, from the latched mode.
  always_comb begin
    v_last_s = VL_N15;
    case ({mode_pal_q, mode_sd_q})
      2'b00:   v_last_s = VL_N15;
      2'b01:   v_last_s = VL_N31;
      2'b10:   v_last_s = VL_P15;
      2'b11:   v_last_s = VL_P31;
      default: v_last_s = VL_N15;
    endcase
  end

  // Divider, raster advance, mode latch at (0,0) and derived blank/sync.
  always_comb begin
    div_last_s    = mode_sd_q ? DIV_LAST_31K : DIV_LAST_15K;
    div_d         = div_q + DIV_ONE;
    ce_pix_d      = 1'b0;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hblank_d      = hblank_q;
    hsync_d       = hsync_q;
    vblank_d      = vblank_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;
    mode_pal_d    = mode_pal_q;
    mode_sd_d     = mode_sd_q;
    v_act_s       = V_ACT_15K;
    vs_beg_s      = VS_BEG_15K;
    vs_end_s      = VS_END_15K;
    if (div_q == div_last_s) begin
      div_d    = '0;
      ce_pix_d = 1'b1;
      if (hcount_q == H_LAST) begin
        hcount_d = 9'd0;
        if (vcount_q == v_last_s) begin
          vcount_d = 10'd0;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 9'd1;
      end
      // New mode applies from the frame-start pixel onward, never mid-frame.
      if ((hcount_d == 9'd0) && (vcount_d == 10'd0)) begin
        mode_pal_d    = pal;
        mode_sd_d     = scandouble;
        frame_start_d = 1'b1;
      end else begin
        frame_start_d = 1'b0;
      end
      if (mode_sd_d) begin
        v_act_s  = V_ACT_31K;
        vs_beg_s = VS_BEG_31K;
        vs_end_s = VS_END_31K;
      end else begin
        v_act_s  = V_ACT_15K;
        vs_beg_s = VS_BEG_15K;
        vs_end_s = VS_END_15K;
      end
      hblank_d = (hcount_d >= H_ACT);
      hsync_d  = (hcount_d >= HS_BEG) && (hcount_d < HS_END);
      vblank_d = (vcount_d >= v_act_s);
      vsync_d  = (vcount_d >= vs_beg_s) && (vcount_d < vs_end_s);
    end else begin
      ce_pix_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      ce_pix_q      <= 1'b0;
      hcount_q      <= H_LAST;
      vcount_q      <= VL_N15;
      hblank_q      <= 1'b1;
      hsync_q       <= 1'b0;
      vblank_q      <= 1'b1;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
      mode_pal_q    <= 1'b0;
      mode_sd_q     <= 1'b0;
    end else begin
      div_q         <= div_d;
      ce_pix_q      <= ce_pix_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hblank_q      <= hblank_d;
      hsync_q       <= hsync_d;
      vblank_q      <= vblank_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      mode_pal_q    <= mode_pal_d;
      mode_sd_q     <= mode_sd_d;
    end
  end

  assign ce_pix      = ce_pix_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign HBlank      = hblank_q;
  assign HSync       = hsync_q;
  assign VBlank      = vblank_q;
  assign VSync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen against a pixel-index raster model,
// using a shrunken raster so several whole frames fit in a short run.
module tb_video_timing_gen;

  localparam int CE_DIV = 4;
  localparam int HA  = 16;
  localparam int HSS = 18;
  localparam int HSE = 22;
  localparam int HT  = 24;
  localparam int VA  = 10;
  localparam int VSS = 12;
  localparam int VSL = 2;
  localparam int VTN = 16;
  localparam int VTP = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pal = 1'b0;
  logic       scandouble = 1'b0;
  logic       ce_pix;
  logic [8:0] hcount;
  logic [9:0] vcount;
  logic       HBlank, HSync, VBlank, VSync, frame_start;

  video_timing_gen #(
    .CE_DIV(CE_DIV), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .H_TOTAL(HT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
    .V_TOTAL_NTSC(VTN), .V_TOTAL_PAL(VTP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pal(pal), .scandouble(scandouble),
    .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount), .HBlank(HBlank),
    .HSync(HSync), .VBlank(VBlank), .VSync(VSync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int vtot(input bit p, input bit s);
    return (p ? VTP : VTN) * (s ? 2 : 1);
  endfunction

  // Reference model: position as a linear pixel index inside the frame.
  int m_cnt, m_h, m_v, m_idx;
  bit m_pal, m_sd, m_ce, m_fs;
  // Independent frame statistics observed from the DUT outputs.
  int pix_cnt, vmax, clk_fs, last_len, last_vmax, last_clks;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        m_cnt = 0; m_h = HT - 1; m_v = VTN - 1; m_pal = 1'b0; m_sd = 1'b0;
        m_ce = 1'b0; m_fs = 1'b0;
        pix_cnt = 0; vmax = 0; clk_fs = 0;
      end else begin
        m_cnt++;
        m_ce = (m_cnt == (m_sd ? CE_DIV / 2 : CE_DIV));
        m_fs = 1'b0;
        if (m_ce) begin
          m_cnt = 0;
          m_idx = ((m_v * HT + m_h) + 1) % (HT * vtot(m_pal, m_sd));
          m_h = m_idx % HT;
          m_v = m_idx / HT;
          if (m_idx == 0) begin
            m_pal = pal; m_sd = scandouble; m_fs = 1'b1;
          end
        end
        clk_fs++;
        if (ce_pix === 1'b1) begin
          if (frame_start === 1'b1) begin
            last_len = pix_cnt; last_vmax = vmax; last_clks = clk_fs;
            pix_cnt = 1; vmax = int'(vcount); clk_fs = 0;
          end else begin
            pix_cnt++;
            if (int'(vcount) > vmax) vmax = int'(vcount);
          end
        end
      end
      check_val("ce_pix", ce_pix, m_ce);
      check_val("hcount", hcount, m_h);
      check_val("vcount", vcount, m_v);
      check_val("frame_start", frame_start, m_fs);
      check_val("HBlank", HBlank, m_h >= HA);
      check_val("HSync", HSync, (m_h >= HSS) && (m_h < HSE));
      check_val("VBlank", VBlank, m_v >= VA * (m_sd ? 2 : 1));
      check_val("VSync", VSync, (m_v >= VSS * (m_sd ? 2 : 1)) &&
                                (m_v < (VSS + VSL) * (m_sd ? 2 : 1)));
    end
  end

  task automatic release_and_check_first_pixel();
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    for (int i = 1; i <= CE_DIV; i++) begin
      @(posedge clk);
      #2;
      check_val("first_ce_timing", ce_pix, (i == CE_DIV));
    end
    check_val("first_h", hcount, 0);
    check_val("first_v", vcount, 0);
    check_val("first_fs", frame_start, 1);
    check_val("first_hblank", HBlank, 0);
    check_val("first_vblank", VBlank, 0);
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(ce_pix === 1'b1 && frame_start === 1'b1) && n < 6000);
    if (n >= 6000) check_val("frame_start_timeout", 0, 1);
  endtask

  task automatic check_frame(input string tag, input int lines, input int div);
    check_val({tag, "_len"}, last_len, HT * lines);
    check_val({tag, "_vmax"}, last_vmax, lines - 1);
    check_val({tag, "_clks"}, last_clks, HT * lines * div);
  endtask

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(ce_pix === 1'b1 && hcount == 9'(h) && vcount == 10'(v)) && n < 6000);
    if (n >= 6000) check_val("position_timeout", 0, 1);
  endtask

  initial begin
    release_and_check_first_pixel();

    // NTSC 15 kHz full frame
    wait_fs();
    check_frame("ntsc", VTN, CE_DIV);

    // PAL requested mid-frame: current frame stays NTSC
    wait_pos(5, 5);
    pal = 1'b1;
    wait_fs();
    check_frame("ntsc_before_pal", VTN, CE_DIV);
    wait_fs();
    check_frame("pal", VTP, CE_DIV);

    // NTSC scandoubled: twice the lines, half the divider, same frame time
    pal = 1'b0;
    scandouble = 1'b1;
    wait_fs();
    check_frame("pal_before_sd", VTP, CE_DIV);
    wait_fs();
    check_frame("ntsc_sd", 2 * VTN, CE_DIV / 2);

    // Randomized mode changes at arbitrary points
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 300)) @(posedge clk);
      #3;
      pal = 1'($urandom);
      scandouble = 1'($urandom);
    end

    // Mid-frame async reset in NTSC 15 kHz
    pal = 1'b0;
    scandouble = 1'b0;
    wait_fs();
    wait_fs();
    wait_pos(15, 7);
    #1 reset_n = 1'b0;
    #1;
    check_val("rst_ce", ce_pix, 0);
    check_val("rst_h", hcount, HT - 1);
    check_val("rst_v", vcount, VTN - 1);
    check_val("rst_hblank", HBlank, 1);
    check_val("rst_vblank", VBlank, 1);
    check_val("rst_hsync", HSync, 0);
    check_val("rst_vsync", VSync, 0);
    check_val("rst_fs", frame_start, 0);
    release_and_check_first_pixel();
    wait_fs();
    check_frame("ntsc_after_reset", VTN, CE_DIV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
